// File: rtl/jtag_host_driver_if.sv
// jtag_host_driver_if: command/response handshake bundle between host logic and the JTAG driver
interface jtag_host_driver_if #(
  parameter int MAX_LEN = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [5:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG initiator walking the TAP from Run-Test/Idle for shift/runtest/reset commands
module jtag_host_driver #(
  parameter int DIV         = 2,
  parameter int MAX_LEN     = 32,
  parameter bit TRST_ACT_LO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_host_driver_if.slave bus,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  output logic              trst,
  input  logic              tdo
);
  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RUN, RST, RESP} state_t;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  state_t r_state, w_nstate;
  logic [DW-1:0] r_div;
  logic r_tck, r_tms, r_tdi;
  logic [5:0] r_cnt, w_ncnt, r_len, w_len, w_clen;
  logic [1:0] r_op, w_op;
  logic [MAX_LEN-1:0] r_data, w_data, r_rsp, w_sh;
  logic w_act, w_edge, w_fall, w_rise, w_acc, w_last, w_tms, w_tdi;
  assign w_act  = r_state inside {PRE, SHIFT, POST, RUN, RST};
  assign w_edge = w_act && r_div == DW'(DIV - 1);
  assign w_fall = w_edge && r_tck;
  assign w_rise = w_edge && !r_tck;
  assign w_acc  = bus.cmd_valid && r_state == IDLE;
  assign w_clen = bus.cmd_op == 2'd3 ? bus.cmd_len
                : bus.cmd_len == 6'd0 ? 6'd1
                : bus.cmd_len > 6'(MAX_LEN) ? 6'(MAX_LEN) : bus.cmd_len;
  assign w_op   = w_acc ? bus.cmd_op : r_op;
  assign w_len  = w_acc ? w_clen : r_len;
  assign w_data = w_acc ? bus.cmd_data : r_data;
  assign w_last = r_state == PRE  ? r_cnt == (r_op == 2'd1 ? 6'd3 : 6'd2)
                : r_state == POST ? r_cnt == 6'd1
                : r_state == RST  ? r_cnt == 6'd5
                : r_cnt == r_len - 6'd1;
  // next state and step index; steps advance only when a TCK completes on its falling edge
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (w_acc) begin
      w_ncnt   = 6'd0;
      w_nstate = bus.cmd_op == 2'd0 ? RST : bus.cmd_op != 2'd3 ? PRE : bus.cmd_len == 6'd0 ? RESP : RUN;
    end else if (w_fall) begin
      w_ncnt   = w_last ? 6'd0 : r_cnt + 6'd1;
      w_nstate = !w_last ? r_state : r_state == PRE ? SHIFT : r_state == SHIFT ? POST : RESP;
    end else if (r_state == RESP && bus.rsp_ready)
      w_nstate = IDLE;
  end
  assign w_sh  = w_data >> w_ncnt;
  assign w_tms = w_nstate == PRE   ? (w_op == 2'd1 ? w_ncnt < 6'd2 : w_ncnt == 6'd0)
               : w_nstate == SHIFT ? w_ncnt == w_len - 6'd1
               : w_nstate == POST  ? w_ncnt == 6'd0
               : w_nstate == RUN   ? 1'b0
               : w_nstate == RST   ? w_ncnt < 6'd5
               : r_tms;
  assign w_tdi = w_nstate == SHIFT && w_sh[0];
  // state register; async reset abandons any TAP walk in progress
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  // TCK divider, pin registers, command latch and TDO capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div  <= '0;
      r_tck  <= 1'b0;
      r_tms  <= 1'b1;
      r_tdi  <= 1'b0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_op   <= '0;
      r_data <= '0;
      r_rsp  <= '0;
    end else begin
      r_cnt <= w_ncnt;
      r_div <= w_act && !w_edge ? r_div + DW'(1) : '0;
      r_tck <= w_act && (w_edge ? !r_tck : r_tck);
      if (w_acc | w_fall) begin
        r_tms <= w_tms;
        r_tdi <= w_tdi;
      end
      if (w_acc) begin
        r_op   <= bus.cmd_op;
        r_len  <= w_clen;
        r_data <= bus.cmd_data;
        r_rsp  <= '0;
      end else if (w_rise && r_state == SHIFT)
        r_rsp <= r_rsp | (MAX_LEN'(tdo) << r_cnt);
    end
  assign tck           = r_tck;
  assign tms           = r_tms;
  assign tdi           = r_tdi;
  assign trst          = TRST_ACT_LO ? r_state != RST : r_state == RST;
  assign bus.cmd_ready = r_state == IDLE;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_data  = r_rsp;
endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: randomized and directed commands against a TAP model and a shift-register reference
module tb_jtag_host_driver;
  localparam int DIV = 2;
  localparam int ML  = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi, trst;
  logic tdo = 1'b0;
  jtag_host_driver_if #(.MAX_LEN(ML)) b();
  jtag_host_driver #(.DIV(DIV), .MAX_LEN(ML), .TRST_ACT_LO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave),
    .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
  );
  always #5 clk = ~clk;

  // IEEE 1149.1 TAP: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
  // 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR; starts in an arbitrary state
  logic [3:0] nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  logic [3:0] nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  logic [3:0] ts = 4'd11;
  logic [31:0] dr = 32'h1234_5678;
  logic [3:0] irs = 4'd0, ir = 4'd0;
  always @(posedge tck) begin
    if (ts == 4'd4) dr <= {tdi, dr[31:1]};
    if (ts == 4'd10) irs <= 4'b0001;
    if (ts == 4'd11) irs <= {tdi, irs[3:1]};
    if (ts == 4'd15) ir <= irs;
    ts <= tms ? nx1[ts] : nx0[ts];
  end
  always @(negedge tck) tdo <= ts == 4'd4 ? dr[0] : ts == 4'd11 ? irs[0] : 1'b0;

  bit q_tms[$], q_tdi[$];
  int n_rise = 0, n_trst = 0;
  always @(posedge tck) begin
    q_tms.push_back(tms);
    q_tdi.push_back(tdi);
    n_rise <= n_rise + 1;
  end
  always @(negedge clk) if (rst_n && trst === 1'b0) n_trst <= n_trst + 1;

  int checks = 0, failures = 0;
  int s_rise = 0, s_trst = 0;
  logic [63:0] m_dr = 64'h1234_5678;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d);
    int k = 0;
    while (b.cmd_ready !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    b.cmd_valid = 1'b1; b.cmd_op = op; b.cmd_len = len; b.cmd_data = d;
    @(posedge clk); #1;
    b.cmd_valid = 1'b0;
    s_rise = n_rise;
    s_trst = n_trst;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (b.rsp_valid !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic take_rsp(output logic [31:0] r);
    r = b.rsp_data;
    b.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b.rsp_ready = 1'b0;
  endtask

  task automatic exec(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d, input bit crsp);
    int L, n, cyc;
    logic [63:0] msk, er, ot, oi, xt, xi, dd;
    logic [3:0] e_ir;
    logic [31:0] r;
    bit et[$], ei[$];
    L = op == 2'd3 ? int'(len) : len == 6'd0 ? 1 : len > ML ? ML : int'(len);
    msk = (64'd1 << L) - 64'd1;
    dd = {32'd0, d} & msk;
    er = 64'd0;
    e_ir = ir;
    if (op == 2'd0) begin
      repeat (5) et.push_back(1'b1);
      et.push_back(1'b0);
      repeat (6) ei.push_back(1'b0);
    end else if (op == 2'd3) begin
      repeat (L) begin et.push_back(1'b0); ei.push_back(1'b0); end
    end else begin
      et.push_back(1'b1);
      if (op == 2'd1) et.push_back(1'b1);
      et.push_back(1'b0); et.push_back(1'b0);
      repeat (op == 2'd1 ? 4 : 3) ei.push_back(1'b0);
      for (int k = 0; k < L; k++) begin et.push_back(k == L - 1); ei.push_back(d[k]); end
      et.push_back(1'b1); et.push_back(1'b0);
      ei.push_back(1'b0); ei.push_back(1'b0);
      if (op == 2'd2) begin
        er = m_dr & msk;
        m_dr = ((m_dr >> L) | (dd << (32 - L))) & 64'hFFFF_FFFF;
      end else begin
        er = ((dd << 4) | 64'd1) & msk;
        e_ir = 4'(((dd << 4) | 64'd1) >> L);
      end
    end
    n = et.size();
    start_cmd(op, len, d);
    wait_rsp(cyc);
    chk("latency", 64'(cyc), 64'(2 * DIV * n));
    chk("tck_rises", 64'(n_rise - s_rise), 64'(n));
    ot = 0; oi = 0; xt = 0; xi = 0;
    for (int k = 0; k < n; k++) begin
      xt[k] = et[k];
      xi[k] = ei[k];
      if (s_rise + k < q_tms.size()) begin ot[k] = q_tms[s_rise + k]; oi[k] = q_tdi[s_rise + k]; end
    end
    chk("tms_seq", ot, xt);
    chk("tdi_seq", oi, xi);
    chk("trst_clks", 64'(n_trst - s_trst), op == 2'd0 ? 64'(2 * DIV * 6) : 64'd0);
    chk("tap_idle", 64'(ts), 64'd1);
    chk("ir_value", 64'(ir), 64'(e_ir));
    take_rsp(r);
    if (crsp) chk("rsp_data", 64'(r), er);
    chk("tck_idle", 64'(tck), 64'd0);
    chk("ready_idle", 64'(b.cmd_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, r;
    logic [1:0] op;
    logic [5:0] len;
    int cyc, k;
    bit held;
    b.cmd_valid = 1'b0; b.cmd_op = 2'd0; b.cmd_len = 6'd0; b.cmd_data = '0; b.rsp_ready = 1'b0;
    #12;
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_trst", 64'(trst), 64'd1);
    chk("rst_ready", 64'(b.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(b.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(b.rsp_data), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exec(2'd0, 6'd0, 32'h0, 1'b1);
    exec(2'd2, 6'd8, 32'hA5, 1'b1);
    exec(2'd2, 6'd32, 32'hDEAD_BEEF, 1'b1);
    exec(2'd2, 6'd32, $urandom, 1'b1);
    exec(2'd1, 6'd4, 32'h3, 1'b1);
    exec(2'd3, 6'd0, 32'h0, 1'b1);
    exec(2'd3, 6'd10, 32'h0, 1'b1);
    exec(2'd2, 6'd0, $urandom, 1'b1);
    exec(2'd2, 6'd40, $urandom, 1'b1);
    exec(2'd1, 6'd0, $urandom, 1'b1);
    for (int i = 0; i < 14; i++) begin
      op  = 2'($urandom_range(0, 3));
      len = op == 2'd3 ? 6'($urandom_range(0, 12)) : op == 2'd1 ? 6'($urandom_range(0, 9)) : 6'($urandom_range(0, 40));
      exec(op, len, $urandom, 1'b1);
    end
    start_cmd(2'd1, 6'd4, $urandom);
    wait_rsp(cyc);
    chk("hold_latency", 64'(cyc), 64'(2 * DIV * 10));
    held = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      held &= b.rsp_valid === 1'b1 && b.rsp_data === 32'h1 && b.cmd_ready === 1'b0 && tck === 1'b0;
    end
    chk("rsp_hold", 64'(held), 64'd1);
    b.rsp_ready = 1'b1; b.cmd_valid = 1'b1; b.cmd_op = 2'd3; b.cmd_len = 6'd3; b.cmd_data = '0;
    @(posedge clk); #1;
    b.rsp_ready = 1'b0;
    chk("rsp_clear", 64'(b.rsp_valid), 64'd0);
    chk("no_bypass", 64'(b.cmd_ready), 64'd1);
    @(posedge clk); #1;
    b.cmd_valid = 1'b0;
    chk("accept_next", 64'(b.cmd_ready), 64'd0);
    s_rise = n_rise;
    wait_rsp(cyc);
    chk("run3_latency", 64'(cyc), 64'(2 * DIV * 3));
    chk("run3_rises", 64'(n_rise - s_rise), 64'd3);
    take_rsp(r);
    chk("run3_rsp", 64'(r), 64'd0);
    start_cmd(2'd2, 6'd16, $urandom);
    k = 0;
    while (n_rise - s_rise < 9 && k < 200) begin @(posedge clk); #1; k++; end
    chk("abort_reach", 64'(n_rise - s_rise), 64'd9);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tms", 64'(tms), 64'd1);
    chk("abort_tdi", 64'(tdi), 64'd0);
    chk("abort_ready", 64'(b.cmd_ready), 64'd1);
    chk("abort_rsp_valid", 64'(b.rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exec(2'd0, 6'd0, 32'h0, 1'b1);
    exec(2'd2, 6'd32, $urandom, 1'b0);
    exec(2'd2, 6'd13, $urandom, 1'b1);
    exec(2'd2, 6'd32, $urandom, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
